led_stream_rx: RTL
==================

// Module: led_stream_rx
// PURPOSE
//   Receiving end of the LED-board serial link (clock / data / latch) driven by the lamp driver.
//   Oversamples the three link lines in the i_clk domain and deserialises c_bpc-bit channel words.
//   Writes each word into a framebuffer-style write port, then flags frame completion on latch.
//   Used as a loopback checker and as the front end of the downstream board emulator.
// PARAMETERS
//   c_ledboards  30    LED boards in the chain; c_channels = c_ledboards*32
//   c_bpc        12    bits per channel word, MSB first on the link
//   c_timeout    4096  idle i_clk cycles before a partial frame is discarded (LED_RX_TIMEOUT_EN only)
// PORTS
//   i_clk        in   1                    system clock; all logic on rising edge
//   i_rst        in   1                    synchronous, active-high reset
//   i_sclk       in   1                    link clock, asynchronous to i_clk
//   i_sdai       in   1                    link data, valid on i_sclk rising edge
//   i_slat       in   1                    link latch, active-high pulse after the last bit
//   o_wen        out  1                    one-cycle write strobe
//   o_waddr      out  $clog2(c_channels)   channel address of o_wdata
//   o_wdata      out  c_bpc                received channel word
//   o_frame_ok   out  1                    one-cycle pulse: latch seen after exactly c_channels whole words
//   o_frame_err  out  1                    one-cycle pulse: latch seen with short, long or partial frame
//   o_busy       out  1                    high while a frame is in progress (state RECV)
// BEHAVIOUR
//   - Reset: all outputs 0; shift reg, bit count, word count 0; state IDLE; sync FFs 0.
//   - i_sclk, i_sdai, i_slat each pass through a 2-FF synchroniser, then a third edge-detect stage.
//     Rise = sync2 & ~sync3. The i_sdai sample used is the synchronised value aligned with the sclk stage.
//   - Requirement: the link high and low phases each last >= 3 i_clk cycles (100 MHz vs 2 MHz: met).
//   - FSM: IDLE -(sclk rise)-> RECV; RECV -(slat rise)-> DONE; DONE -> IDLE after 1 cycle.
//   - IDLE: the first sclk rise shifts its bit in, like any later rise.
//   - On each sclk rise, shift = {shift[c_bpc-2:0], sdai}; bitcnt++.
//   - When bitcnt reaches c_bpc:
//     - Register o_wen=1, o_wdata=word, o_waddr=c_channels-1-wordcnt.
//     - Daisy chain order: the first word shifted is the farthest channel.
//     - Clear bitcnt; wordcnt++ (saturates at c_channels).
//   - Latency: o_wen high in the 4th i_clk cycle after the cycle in which sync1 first captures the final sclk rise.
//   - Overflow: words with wordcnt == c_channels are not written (o_wen stays 0); overflow flag set.
//   - slat rise (in RECV or IDLE):
//     - o_frame_ok=1 iff wordcnt==c_channels && bitcnt==0 && !overflow; otherwise o_frame_err=1.
//     - Clear wordcnt, bitcnt, shift and overflow.
//     - A latch in IDLE with zero bits received gives o_frame_err.
//   - sclk rise and slat rise in the same cycle: the latch wins and that bit is discarded.
//   - o_frame_ok and o_frame_err are mutually exclusive and never asserted together with o_wen.
//   - o_wen/o_frame_* are pulses: exactly 1 cycle high per event.
//   - Reset mid-frame: all progress is dropped. The next frame starts at wordcnt 0.
//     Bits from the interrupted frame are not recovered.
//   - Counter widths: bitcnt $clog2(c_bpc+1); wordcnt $clog2(c_channels+1).
// CONFIGURATION
//   LED_RX_TIMEOUT_EN defined:
//     - An idle counter resets on every sclk or slat rise and counts in RECV.
//     - On reaching c_timeout: pulse o_frame_err; clear counters; go to IDLE.
//       No writes are undone.
//   LED_RX_TIMEOUT_EN undefined:
//     - No idle counter; RECV waits indefinitely for slat; the c_timeout parameter is ignored.
// TESTING  (bench uses c_ledboards=1 -> 32 channels, c_bpc=12, i_clk 100 MHz, link 2 MHz)
//   1 Full frame, ch k = 12'h100+k, last ch first, latch
//     -> 32 writes; addr 31 first = 12'h11F, addr 0 last = 12'h100
//     -> then one o_frame_ok, no o_frame_err
//   2 31 words then latch -> 31 writes (addr 31..1), o_frame_err, o_frame_ok stays 0
//   3 33 words then latch -> 32 writes only, 33rd dropped, o_frame_err
//   4 5 bits of 12'hABC then latch -> no write; o_frame_err; next full frame -> o_frame_ok
//   5 i_rst pulsed after 10 words, then full frame -> counting restarts; writes addr 31..0; o_frame_ok
//   6 LED_RX_TIMEOUT_EN, c_timeout=64: 3 words then 100-cycle silence
//     -> o_frame_err 64 cycles after the last edge, o_busy=0

Source files
------------

// File: rtl/led_stream_rx.sv
// ============================================================================
// Module   : led_stream_rx
// Purpose  : LED-board serial link receiver (sclk/sdai/slat) with a
//            framebuffer write port and frame-completion status pulses.
// Options  : LED_RX_TIMEOUT_EN adds an idle timeout that discards partial frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_stream_rx #(
  parameter int C_LEDBOARDS = 30,
  parameter int C_BPC       = 12,
  parameter int C_TIMEOUT   = 4096
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_sclk,
  input  logic                                 i_sdai,
  input  logic                                 i_slat,
  output logic                                 o_wen,
  output logic [$clog2(C_LEDBOARDS*32)-1:0]    o_waddr,
  output logic [C_BPC-1:0]                     o_wdata,
  output logic                                 o_frame_ok,
  output logic                                 o_frame_err,
  output logic                                 o_busy
);

  localparam int c_channels = C_LEDBOARDS * 32;
  localparam int c_aw       = $clog2(c_channels);
  localparam int c_bw       = $clog2(C_BPC + 1);
  localparam int c_ww       = $clog2(c_channels + 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_recv = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_channels - 1);

  generate
    if (C_BPC < 2 || C_TIMEOUT < 1 || C_LEDBOARDS < 1) begin : g_bad_cfg
      $error("led_stream_rx: unsupported parameter set");
    end
  endgenerate

  // [0]=sync1, [1]=sync2, [2]=edge-detect stage
  logic [2:0]        r_sclk_s;
  logic [2:0]        r_slat_s;
  logic [1:0]        r_sdai_s;

  logic [1:0]        r_state;
  logic [C_BPC-1:0]  r_shift;
  logic [c_bw-1:0]   r_bitcnt;
  logic [c_ww-1:0]   r_wordcnt;
  logic              r_ovf;

  logic              r_wen_p;
  logic              r_ok_p;
  logic              r_err_p;
  logic [c_aw-1:0]   r_waddr_p;
  logic [C_BPC-1:0]  r_wdata_p;

  logic              w_sclk_rise;
  logic              w_slat_rise;
  logic              w_sdai;
  logic [C_BPC-1:0]  w_word;
  logic              w_bit_last;
  logic              w_full;
  logic [c_aw-1:0]   w_addr;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_slat_rise = r_slat_s[1] & ~r_slat_s[2];
  assign w_sdai      = r_sdai_s[1];
  assign w_word      = {r_shift[C_BPC-2:0], w_sdai};
  assign w_bit_last  = (r_bitcnt == c_bw'(C_BPC - 1));
  assign w_full      = (r_wordcnt == c_ww'(c_channels));
  // First word on the link belongs to the farthest channel.
  assign w_addr      = c_last_addr - r_wordcnt[c_aw-1:0];
  assign o_busy      = (r_state == c_st_recv);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_s <= '0;
      r_slat_s <= '0;
      r_sdai_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], i_sclk};
      r_slat_s <= {r_slat_s[1:0], i_slat};
      r_sdai_s <= {r_sdai_s[0], i_sdai};
    end
  end

`ifdef LED_RX_TIMEOUT_EN
  localparam int c_tw = $clog2(C_TIMEOUT + 1);
  logic [c_tw-1:0] r_idle;
  logic            w_timeout;

  assign w_timeout = (r_state == c_st_recv) && (r_idle == c_tw'(C_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_sclk_rise || w_slat_rise || w_timeout) begin
      r_idle <= '0;
    end else if (r_state == c_st_recv) begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
`endif

  // Events are staged one cycle so writes and frame pulses share a single output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= c_st_idle;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_wordcnt   <= '0;
      r_ovf       <= 1'b0;
      r_wen_p     <= 1'b0;
      r_ok_p      <= 1'b0;
      r_err_p     <= 1'b0;
      r_waddr_p   <= '0;
      r_wdata_p   <= '0;
      o_wen       <= 1'b0;
      o_waddr     <= '0;
      o_wdata     <= '0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_wen       <= r_wen_p;
      o_waddr     <= r_waddr_p;
      o_wdata     <= r_wdata_p;
      o_frame_ok  <= r_ok_p;
      o_frame_err <= r_err_p;
      r_wen_p     <= 1'b0;
      r_ok_p      <= 1'b0;
      r_err_p     <= 1'b0;

      if (w_slat_rise) begin
        if (w_full && (r_bitcnt == '0) && !r_ovf) begin
          r_ok_p <= 1'b1;
        end else begin
          r_err_p <= 1'b1;
        end
        r_shift   <= '0;
        r_bitcnt  <= '0;
        r_wordcnt <= '0;
        r_ovf     <= 1'b0;
        r_state   <= c_st_done;
      end else if (w_sclk_rise) begin
        r_state <= c_st_recv;
        r_shift <= w_word;
        if (w_bit_last) begin
          r_bitcnt <= '0;
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_wen_p   <= 1'b1;
            r_wdata_p <= w_word;
            r_waddr_p <= w_addr;
            r_wordcnt <= r_wordcnt + 1'b1;
          end
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end else if (w_timeout) begin
        r_err_p   <= 1'b1;
        r_shift   <= '0;
        r_bitcnt  <= '0;
        r_wordcnt <= '0;
        r_ovf     <= 1'b0;
        r_state   <= c_st_idle;
      end else if (r_state == c_st_done) begin
        r_state <= c_st_idle;
      end
    end
  end

endmodule

`default_nettype wire
